alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
Parameters:
REQ-001 WIDTH, 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHAMT_W, $clog2(WIDTH), shift-amount width.
REQ-003 MUL_EN, 1, when 0 MULTU decodes as illegal and no multiplier logic is built.
Ports:
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request; sampled only when busy=0.
REQ-007 ALUop  in  2  00=ADD, 01=SUB, 11=OR, 10=decode funct.
REQ-008 funct  in  6  R-type function field; used only when ALUop=10.
REQ-009 a, b  in  WIDTH  operands.
REQ-010 shamt  in  SHAMT_W  shift amount for SLL.
REQ-011 busy  out  1  high while an operation is in flight.
REQ-012 done  out  1  one-cycle pulse; result, zero and illegal are valid in that cycle.
REQ-013 result  out  WIDTH  operation result.
REQ-014 zero  out  1  result==0, registered alongside result.
REQ-015 illegal  out  1  undecodable ALUop/funct combination.

Function
REQ-016 funct map: 100001 ADDU -> ADD; 100011 SUBU -> SUB; 000000 SLL -> b<<shamt; 001000 JR -> ADD; 101010 SLT -> signed a<b, zero-extended to WIDTH; 100100 AND; 100101 OR; 100110 XOR; 011001 MULTU -> low WIDTH bits of unsigned a*b.
REQ-017 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-018 FSM states: IDLE, EXEC, MUL.
REQ-019 IDLE with start=1: latch a, b, shamt and the decoded op; go to MUL if the op is MULTU, else go to EXEC.
REQ-020 EXEC lasts one cycle: register result/zero/illegal, pulse done, return to IDLE; latency start-to-done is 1 cycle.
REQ-021 MUL is an iterative shift-add of one bit per cycle for WIDTH cycles; done pulses in cycle WIDTH+1 after the start edge, then return to IDLE.
REQ-022 busy=1 in EXEC and MUL, 0 in IDLE; busy is low in the done cycle's following edge, so back-to-back start in the cycle after done is accepted.
REQ-023 start while busy=1 is ignored and never queued; input changes while busy do not affect the in-flight op.
REQ-024 Illegal decode: take the EXEC path, result=0, zero=1, illegal=1, done pulses as normal; no X is ever driven.
REQ-025 result, zero and illegal hold their last value until the next done.

Reset
REQ-026 reset forces IDLE with busy=0, done=0, result=0, zero=0, illegal=0, and clears the multiplier accumulator.
REQ-027 reset during EXEC or MUL aborts the op: no done pulse is issued.
REQ-028 reset has priority over start in the same cycle.

Structure
REQ-029 A shared package alu_pkg holds the ALUop encodings, funct constants, internal op enum (AND, OR, ADD, XOR, SLT, SLL, SUB, MULTU, ILL) and FSM state type.
REQ-030 The combinational decoder is a sub-module alu_op_dec (ALUop, funct -> op enum); the FSM and datapath stay in alu_seq.

Verification
REQ-031 Run all scenarios with WIDTH=32:
- ALUop=10, funct=100001, a=5, b=7, start -> next cycle done=1, result=12, zero=0.
- ALUop=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1 (signed SLT); a=1, b=0xFFFFFFFF -> result=0, zero=1.
- MULTU a=7, b=6 -> busy for 32 cycles, done in cycle 33, result=42; start pulsed mid-op is ignored, no second done.
- funct=111111, ALUop=10 -> done=1, illegal=1, result=0; with MUL_EN=0, funct=011001 -> illegal=1.
- reset asserted in MUL cycle 10 -> busy=0 next cycle, done never pulses, result=0; a following ADD a=1, b=1 gives result=2.
- SUB a=3, b=3 -> result=0, zero=1; SLL b=1, shamt=31 -> result=0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: ALUop/funct encodings, internal op codes and FSM states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_XOR   = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SUB   = 4'd6,
        OP_MULTU = 4'd7,
        OP_ILL   = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational decoder from ALUop/funct to the internal op code; unknown combinations map to OP_ILL.
module alu_op_dec
    import alu_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output op_e        o_op
);

    always_comb begin
        o_op = OP_ILL;
        case (i_aluop)
            ALUOP_ADD: o_op = OP_ADD;
            ALUOP_SUB: o_op = OP_SUB;
            ALUOP_OR:  o_op = OP_OR;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADDU:  o_op = OP_ADD;
                    FUNCT_SUBU:  o_op = OP_SUB;
                    FUNCT_SLL:   o_op = OP_SLL;
                    FUNCT_JR:    o_op = OP_ADD;
                    FUNCT_SLT:   o_op = OP_SLT;
                    FUNCT_AND:   o_op = OP_AND;
                    FUNCT_OR:    o_op = OP_OR;
                    FUNCT_XOR:   o_op = OP_XOR;
                    // Without a multiplier MULTU is simply another undecodable funct.
                    FUNCT_MULTU: o_op = (MUL_EN != 0) ? OP_MULTU : OP_ILL;
                    default:     o_op = OP_ILL;
                endcase
            end
            default: o_op = OP_ILL;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete via EXEC, MULTU runs a WIDTH-cycle shift-add in MUL.
// Handshake: start is sampled only while busy=0; done is a one-cycle pulse qualifying result/zero/illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int MUL_EN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         ALUop,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal,
    output state_e             o_state
);

    state_e             r_state;
    state_e             w_next_state;
    op_e                w_op;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_mul_result;
    logic               w_accept;
    logic               w_mul_last;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;
    logic               r_done;

    alu_op_dec #(
        .MUL_EN(MUL_EN)
    ) u_dec (
        .i_aluop(ALUop),
        .i_funct(funct),
        .o_op   (w_op)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == SHAMT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = (w_op == OP_MULTU) ? S_MUL : S_EXEC;
            end
            S_EXEC:  w_next_state = S_IDLE;
            S_MUL:   if (w_mul_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_SLL:  w_alu = b << shamt;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_alu = '0;
        endcase
    end

    // Single-cycle ops are evaluated on the accepting edge so done can appear in the EXEC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_MUL) r_cnt <= r_cnt + SHAMT_W'(1);
            else                  r_cnt <= '0;
            if (w_accept && (w_op != OP_MULTU)) begin
                r_result  <= w_alu;
                r_zero    <= (w_alu == '0);
                r_illegal <= (w_op == OP_ILL);
                r_done    <= 1'b1;
            end
            if (w_mul_last) begin
                r_result  <= w_mul_result;
                r_zero    <= (w_mul_result == '0);
                r_illegal <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            logic [WIDTH-1:0] r_mcand;
            logic [WIDTH-1:0] r_mplier;
            logic [WIDTH-1:0] r_acc;
            logic [WIDTH-1:0] w_acc_next;

            assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
            assign w_mul_result = w_acc_next;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mcand  <= '0;
                    r_mplier <= '0;
                    r_acc    <= '0;
                end else if (w_accept) begin
                    r_mcand  <= a;
                    r_mplier <= b;
                    r_acc    <= '0;
                end else if (r_state == S_MUL) begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end
            end
        end else begin : g_no_mul
            assign w_mul_result = '0;
        end
    endgenerate

    assign done    = r_done;
    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;
    assign o_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32) with a second MUL_EN=0 instance for the MULTU-illegal case.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          start_nm;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [SW-1:0] shamt;

  logic          busy, done, zero, illegal;
  logic [W-1:0]  result;
  state_e        dbg_state;

  logic          nm_busy, nm_done, nm_zero, nm_illegal;
  logic [W-1:0]  nm_result;
  state_e        nm_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W), .SHAMT_W(SW), .MUL_EN(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ALUop(aluop), .funct(funct),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done), .result(result),
    .zero(zero), .illegal(illegal), .o_state(dbg_state)
  );

  alu_seq #(.WIDTH(W), .SHAMT_W(SW), .MUL_EN(0)) u_nomul (
    .clk(clk), .reset(reset), .start(start_nm), .ALUop(aluop), .funct(funct),
    .a(a), .b(b), .shamt(shamt), .busy(nm_busy), .done(nm_done), .result(nm_result),
    .zero(nm_zero), .illegal(nm_illegal), .o_state(nm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present an op with start for one edge; returns in the cycle after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [SW-1:0] sa);
    aluop = op;
    funct = fn;
    a     = va;
    b     = vb;
    shamt = sa;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] exp_res,
                            input logic exp_zero, input logic exp_ill);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, exp_zero);
    check({tag, "_illegal"}, illegal, exp_ill);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_nm = 1'b0;
    aluop = 2'b00; funct = 6'b0; a = '0; b = '0; shamt = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b0;
    tick();

    // ADDU 5+7, done in the cycle after start
    issue(2'b10, 6'b100001, 32'd5, 32'd7, 5'd0);
    check_done("addu", 32'd12, 1'b0, 1'b0);
    check("addu_busy", busy, 1'b1);
    tick();
    check("addu_done_low", done, 1'b0);
    check("addu_idle", busy, 1'b0);
    check("addu_hold", result, 32'd12);

    // signed SLT, back-to-back
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check_done("slt_neg", 32'd1, 1'b0, 1'b0);
    tick();
    issue(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd0);
    check_done("slt_pos", 32'd0, 1'b1, 1'b0);
    tick();

    // ALUop-direct and remaining funct ops
    issue(2'b11, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    check_done("or_op", 32'h0000_00FF, 1'b0, 1'b0);
    tick();
    issue(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    check_done("and", 32'h0F00_0F00, 1'b0, 1'b0);
    tick();
    issue(2'b10, 6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    check_done("xor", 32'hF0F0_F0F0, 1'b0, 1'b0);
    tick();
    issue(2'b10, 6'b100011, 32'd0, 32'd1, 5'd0);
    check_done("subu_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    issue(2'b10, 6'b001000, 32'd2, 32'd3, 5'd0);
    check_done("jr", 32'd5, 1'b0, 1'b0);
    tick();
    issue(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check_done("add_wrap", 32'd1, 1'b0, 1'b0);
    tick();

    // MULTU 7*6: busy 32 cycles, done in cycle 33, mid-op start and operand changes ignored
    issue(2'b10, 6'b011001, 32'd7, 32'd6, 5'd0);
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("mul_busy_c%0d", c), busy, 1'b1);
      check($sformatf("mul_nodone_c%0d", c), done, 1'b0);
      check($sformatf("mul_state_c%0d", c), dbg_state, S_MUL);
      if (c == 10) begin
        start = 1'b1; aluop = 2'b00; a = 32'd100; b = 32'd200;
      end
      if (c == 11) start = 1'b0;
      tick();
    end
    check_done("multu", 32'd42, 1'b0, 1'b0);
    check("multu_busy_low", busy, 1'b0);
    tick();
    check("multu_single_done", done, 1'b0);
    check("multu_hold", result, 32'd42);
    tick();
    check("multu_no_queue", done, 1'b0);

    // undecodable funct
    issue(2'b10, 6'b111111, 32'd9, 32'd9, 5'd0);
    check_done("illegal", 32'd0, 1'b1, 1'b1);
    tick();

    // MULTU on the instance built without a multiplier
    aluop = 2'b10; funct = 6'b011001; a = 32'd7; b = 32'd6;
    start_nm = 1'b1;
    tick();
    start_nm = 1'b0;
    check("nomul_done", nm_done, 1'b1);
    check("nomul_illegal", nm_illegal, 1'b1);
    check("nomul_result", nm_result, 32'd0);
    check("nomul_zero", nm_zero, 1'b1);
    check("nomul_exec", nm_state, S_EXEC);
    tick();

    // reset in MUL cycle 10 aborts the op
    issue(2'b10, 6'b011001, 32'd7, 32'd6, 5'd0);
    for (int c = 1; c < 10; c++) tick();
    check("abort_in_mul", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'd0);
    check("abort_zero", zero, 1'b0);
    check("abort_illegal", illegal, 1'b0);
    for (int c = 0; c < 30; c++) begin
      check($sformatf("abort_nodone_%0d", c), done, 1'b0);
      tick();
    end
    issue(2'b00, 6'b000000, 32'd1, 32'd1, 5'd0);
    check_done("post_abort_add", 32'd2, 1'b0, 1'b0);
    tick();

    // SUB to zero and SLL to the top bit
    issue(2'b01, 6'b000000, 32'd3, 32'd3, 5'd0);
    check_done("sub_zero", 32'd0, 1'b1, 1'b0);
    tick();
    issue(2'b10, 6'b000000, 32'd0, 32'd1, 5'd31);
    check_done("sll31", 32'h8000_0000, 1'b0, 1'b0);
    tick();

    // reset wins over start in the same cycle
    reset = 1'b1;
    issue(2'b00, 6'b000000, 32'd4, 32'd4, 5'd0);
    reset = 1'b0;
    check("rst_prio_busy", busy, 1'b0);
    check("rst_prio_done", done, 1'b0);
    check("rst_prio_result", result, 32'd0);
    tick();
    check("rst_prio_after", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
